// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  localparam int unsigned NbOperandDef = 5;

  typedef enum logic [2:0] {
    RUN,
    MEM_WAIT,
    DRAIN,
    HALTED,
    ERROR
  } ctrl_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detection: a load in EX feeding a register the ID instruction reads.
module pipeline_ctrl_hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned NB_OPERAND = NbOperandDef
) (
  input  logic [NB_OPERAND-1:0] i_rs1,
  input  logic [NB_OPERAND-1:0] i_rs2,
  input  logic                  i_uses_rs1,
  input  logic                  i_uses_rs2,
  input  logic                  i_mem_read,
  input  logic [NB_OPERAND-1:0] i_rd,
  output logic                  o_load_use
);

  always_comb begin
    o_load_use = i_mem_read && (i_rd != '0) &&
                 ((i_uses_rs1 && (i_rd == i_rs1)) || (i_uses_rs2 && (i_rd == i_rs2)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard bubbles, branch flushes,
// data-memory wait/timeout and halt drain.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned NB_OPERAND   = NbOperandDef,
  parameter int unsigned MAX_MEM_WAIT = 15,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NB_OPERAND-1:0] i_if_id_rs1,
  input  logic [NB_OPERAND-1:0] i_if_id_rs2,
  input  logic                  i_if_id_uses_rs1,
  input  logic                  i_if_id_uses_rs2,
  input  logic                  i_if_id_halt,
  input  logic                  i_branch_taken,
  input  logic                  i_id_ex_mem_read,
  input  logic [NB_OPERAND-1:0] i_id_ex_rd,
  input  logic                  i_dmem_req,
  input  logic                  i_dmem_ack,
  output logic                  o_pc_en,
  output logic                  o_if_id_en,
  output logic                  o_id_ex_en,
  output logic                  o_ex_mem_en,
  output logic                  o_mem_wb_en,
  output logic                  o_if_id_flush,
  output logic                  o_id_ex_flush,
  output logic                  o_halted,
  output logic                  o_mem_timeout,
  output logic [31:0]           o_stall_cycles
);

  localparam int unsigned WaitW  = $clog2(MAX_MEM_WAIT + 1);
  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [WaitW-1:0]  WaitMax  = WaitW'(MAX_MEM_WAIT);
  localparam logic [DrainW-1:0] DrainMax = DrainW'(DRAIN_CYCLES);

  ctrl_state_t       state_q, state_d;
  logic [WaitW-1:0]  wait_q, wait_d, wait_inc;
  logic [DrainW-1:0] drain_q, drain_d, drain_inc;
  logic [31:0]       stall_q, stall_d;
  logic              halted_q, halted_d;
  logic              timeout_q, timeout_d;
  logic              load_use;
  logic              mem_freeze;

  pipeline_ctrl_hazard_detect #(
    .NB_OPERAND (NB_OPERAND)
  ) u_hazard_detect (
    .i_rs1      (i_if_id_rs1),
    .i_rs2      (i_if_id_rs2),
    .i_uses_rs1 (i_if_id_uses_rs1),
    .i_uses_rs2 (i_if_id_uses_rs2),
    .i_mem_read (i_id_ex_mem_read),
    .i_rd       (i_id_ex_rd),
    .o_load_use (load_use)
  );

  assign mem_freeze = i_dmem_req && !i_dmem_ack;
  assign wait_inc   = wait_q + WaitW'(1);
  assign drain_inc  = drain_q + DrainW'(1);

  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    drain_d       = '0;
    o_pc_en       = 1'b0;
    o_if_id_en    = 1'b0;
    o_id_ex_en    = 1'b0;
    o_ex_mem_en   = 1'b0;
    o_mem_wb_en   = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;

    unique case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_freeze) begin
          wait_d  = wait_inc;
          state_d = (wait_inc == WaitMax) ? ERROR : MEM_WAIT;
        end else begin
          // An acked (or withdrawn) request cycle decodes exactly like RUN.
          state_d     = RUN;
          o_pc_en     = 1'b1;
          o_if_id_en  = 1'b1;
          o_id_ex_en  = 1'b1;
          o_ex_mem_en = 1'b1;
          o_mem_wb_en = 1'b1;
          if (load_use) begin
            o_pc_en       = 1'b0;
            o_if_id_en    = 1'b0;
            o_id_ex_flush = 1'b1;
          end else if (i_branch_taken) begin
            o_if_id_flush = 1'b1;
          end else if (i_if_id_halt) begin
            o_if_id_flush = 1'b1;
            state_d       = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (mem_freeze) begin
          wait_d  = wait_inc;
          drain_d = drain_q;
          if (wait_inc == WaitMax) state_d = ERROR;
        end else begin
          o_if_id_en    = 1'b1;
          o_id_ex_en    = 1'b1;
          o_ex_mem_en   = 1'b1;
          o_mem_wb_en   = 1'b1;
          o_if_id_flush = 1'b1;
          drain_d       = drain_inc;
          if (drain_inc == DrainMax) state_d = HALTED;
        end
      end
      HALTED, ERROR: begin
        state_d = state_q;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    stall_d = stall_q;
    if (!o_pc_en && (state_q inside {RUN, MEM_WAIT, DRAIN})) begin
      stall_d = sat_inc32(stall_q);
    end

    // Flags rise with the state entry so they are visible in the first HALTED/ERROR cycle.
    halted_d  = halted_q || (state_d == HALTED);
    timeout_d = timeout_q || (state_d == ERROR);

    if (i_rst) begin
      o_pc_en       = 1'b0;
      o_if_id_en    = 1'b0;
      o_id_ex_en    = 1'b0;
      o_ex_mem_en   = 1'b0;
      o_mem_wb_en   = 1'b0;
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      drain_q   <= '0;
      stall_q   <= '0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      drain_q   <= drain_d;
      stall_q   <= stall_d;
      halted_q  <= halted_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_halted       = halted_q && !i_rst;
  assign o_mem_timeout  = timeout_q && !i_rst;
  assign o_stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazards, branches, memory wait/timeout, halt drain, reset.
module tb_pipeline_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, halt, branch, mread, req, ack;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, halted, timeout;
  logic [31:0] stall;
  logic [4:0] en;
  logic [1:0] fl;

  int errors = 0;
  int checks = 0;

  assign en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
  assign fl = {if_id_flush, id_ex_flush};

  pipeline_ctrl #(
    .NB_OPERAND   (5),
    .MAX_MEM_WAIT (3),
    .DRAIN_CYCLES (4)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_if_id_rs1      (rs1),
    .i_if_id_rs2      (rs2),
    .i_if_id_uses_rs1 (u1),
    .i_if_id_uses_rs2 (u2),
    .i_if_id_halt     (halt),
    .i_branch_taken   (branch),
    .i_id_ex_mem_read (mread),
    .i_id_ex_rd       (rd),
    .i_dmem_req       (req),
    .i_dmem_ack       (ack),
    .o_pc_en          (pc_en),
    .o_if_id_en       (if_id_en),
    .o_id_ex_en       (id_ex_en),
    .o_ex_mem_en      (ex_mem_en),
    .o_mem_wb_en      (mem_wb_en),
    .o_if_id_flush    (if_id_flush),
    .o_id_ex_flush    (id_ex_flush),
    .o_halted         (halted),
    .o_mem_timeout    (timeout),
    .o_stall_cycles   (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs1 = '0; rs2 = '0; rd = '0; u1 = 1'b0; u2 = 1'b0;
    halt = 1'b0; branch = 1'b0; mread = 1'b0; req = 1'b0; ack = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk); #1;
    check("rst_en", en, 5'b00000);
    check("rst_fl", fl, 2'b11);
    check("rst_halted", halted, 0);
    check("rst_timeout", timeout, 0);
    tick();
    rst = 1'b0; #1;
    check("run_en", en, 5'b11111);
    check("run_fl", fl, 2'b00);
    check("run_stall0", stall, 0);

    // load x5, ID reads rs1 = 5
    mread = 1'b1; rd = 5'd5; rs1 = 5'd5; u1 = 1'b1; #1;
    check("lu_en", en, 5'b00111);
    check("lu_fl", fl, 2'b01);
    tick(); idle(); #1;
    check("lu_stall", stall, 1);
    check("lu_after_en", en, 5'b11111);

    // load x0 never stalls
    mread = 1'b1; rd = 5'd0; rs1 = 5'd0; u1 = 1'b1; #1;
    check("x0_en", en, 5'b11111);
    check("x0_fl", fl, 2'b00);

    // rs2 hazard, then same match with rs2 unused
    tick(); idle();
    mread = 1'b1; rd = 5'd7; rs2 = 5'd7; u2 = 1'b1; rs1 = 5'd3; u1 = 1'b1; #1;
    check("lu_rs2_en", en, 5'b00111);
    tick(); u2 = 1'b0; #1;
    check("rs2_unused_en", en, 5'b11111);
    check("rs2_stall", stall, 2);

    // branch taken, no hazard
    tick(); idle(); branch = 1'b1; #1;
    check("br_en", en, 5'b11111);
    check("br_fl", fl, 2'b10);

    // branch with load-use: stall wins, branch acts next cycle
    tick(); mread = 1'b1; rd = 5'd9; rs1 = 5'd9; u1 = 1'b1; #1;
    check("br_lu_en", en, 5'b00111);
    check("br_lu_fl", fl, 2'b01);
    tick(); mread = 1'b0; #1;
    check("br_next_en", en, 5'b11111);
    check("br_next_fl", fl, 2'b10);
    check("br_stall", stall, 3);

    // back-to-back load-use
    tick(); idle(); mread = 1'b1; rd = 5'd4; rs1 = 5'd4; u1 = 1'b1; #1;
    check("b2b1_en", en, 5'b00111);
    tick(); rd = 5'd6; rs1 = 5'd1; rs2 = 5'd6; u2 = 1'b1; #1;
    check("b2b2_en", en, 5'b00111);
    tick(); idle(); #1;
    check("b2b_stall", stall, 5);

    // memory waits ended by ack; counter must clear on each ack
    req = 1'b1; #1;
    check("mw_en", en, 5'b00000);
    check("mw_fl", fl, 2'b00);
    tick(); ack = 1'b1; #1;
    check("mw_ack_en", en, 5'b11111);
    tick(); ack = 1'b0;
    tick();
    tick(); ack = 1'b1; #1;
    check("mw_ack2_en", en, 5'b11111);
    tick(); idle(); #1;
    check("mw_no_to", timeout, 0);
    check("mw_stall", stall, 8);

    // timeout after three unacked cycles
    req = 1'b1; #1;
    check("to_a_en", en, 5'b00000);
    tick(); tick(); #1;
    check("to_c_flag", timeout, 0);
    tick(); #1;
    check("to_d_flag", timeout, 1);
    check("to_d_en", en, 5'b00000);
    check("to_d_stall", stall, 11);
    req = 1'b0; branch = 1'b1;
    tick(); #1;
    check("to_sticky", timeout, 1);
    check("to_err_en", en, 5'b00000);
    check("to_err_fl", fl, 2'b00);
    check("to_err_stall", stall, 11);
    rst = 1'b1; #1;
    check("to_rst_flag", timeout, 0);
    check("to_rst_fl", fl, 2'b11);
    tick(); rst = 1'b0; idle(); #1;
    check("to_clr_flag", timeout, 0);
    check("to_clr_stall", stall, 0);
    check("to_clr_en", en, 5'b11111);

    // reset mid-MEM_WAIT leaves no residual wait count
    req = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    tick(); tick(); ack = 1'b1; #1;
    check("mwr_ack_en", en, 5'b11111);
    tick(); idle(); #1;
    check("mwr_no_to", timeout, 0);

    // halt with a 2-cycle memory wait inside the drain
    rst = 1'b1; tick(); rst = 1'b0; idle();
    halt = 1'b1; #1;
    check("h0_en", en, 5'b11111);
    check("h0_fl", fl, 2'b10);
    tick(); halt = 1'b0; #1;
    check("d1_en", en, 5'b01111);
    check("d1_fl", fl, 2'b10);
    tick(); req = 1'b1; #1;
    check("d2_en", en, 5'b00000);
    check("d2_fl", fl, 2'b00);
    tick();
    tick(); req = 1'b0; #1;
    check("d4_en", en, 5'b01111);
    tick();
    tick(); #1;
    check("d6_halted", halted, 0);
    tick(); #1;
    check("h7_halted", halted, 1);
    check("h7_en", en, 5'b00000);
    check("h7_fl", fl, 2'b00);
    check("h7_stall", stall, 6);
    check("h7_timeout", timeout, 0);
    tick(); halt = 1'b1; branch = 1'b1; #1;
    check("h8_halted", halted, 1);
    check("h8_en", en, 5'b00000);
    check("h8_stall", stall, 6);

    // reset mid-drain returns to RUN
    rst = 1'b1; tick(); rst = 1'b0; idle();
    halt = 1'b1;
    tick(); halt = 1'b0;
    tick();
    rst = 1'b1; #1;
    check("dr_rst_en", en, 5'b00000);
    check("dr_rst_fl", fl, 2'b11);
    tick(); rst = 1'b0; #1;
    check("dr_run_en", en, 5'b11111);
    check("dr_run_fl", fl, 2'b00);
    repeat (6) tick();
    #1;
    check("dr_no_halt", halted, 0);
    check("dr_no_stall", stall, 0);
    check("dr_idle_en", en, 5'b11111);
    mread = 1'b1; rd = 5'd2; rs1 = 5'd2; u1 = 1'b1; #1;
    check("dr_lu_en", en, 5'b00111);
    tick(); idle(); #1;
    check("dr_lu_stall", stall, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
